// File: rtl/hps_io_cmd_pkg.sv
// Command codes and state encoding shared by the HPS UIO command decoder.
package hps_io_pkg;

  localparam logic [7:0] CMD_BUTTONS    = 8'h01;
  localparam logic [7:0] CMD_JOY0       = 8'h02;
  localparam logic [7:0] CMD_JOY1       = 8'h03;
  localparam logic [7:0] CMD_JOY2       = 8'h04;
  localparam logic [7:0] CMD_JOY3       = 8'h05;
  localparam logic [7:0] CMD_STATUS_SET = 8'h1E;
  localparam logic [7:0] CMD_STATUS_GET = 8'h29;

  localparam int IO_EN_BIT = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } ioState_t;

endpackage

// File: rtl/hps_io_cmd.sv
// Frames UIO transactions from the HPS SPI front end and routes data words to
// core-facing registers; gp_in carries the return word back to the HPS.
module hps_io_cmd
  import hps_io_pkg::*;
#(
  parameter int          NUM_JOY     = 4,
  parameter logic [63:0] STATUS_INIT = 64'h0
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] gp_out,
  input  logic        io_strobe,
  output logic [15:0] gp_in,
  output logic [1:0]  buttons,
  output logic [7:0]  switches,
  output logic [31:0] joy_0,
  output logic [31:0] joy_1,
  output logic [31:0] joy_2,
  output logic [31:0] joy_3,
  output logic [63:0] status,
  output logic        status_upd
);

  logic        w_ioEn;
  logic [15:0] w_word;
  logic        w_ioEnFall;
  logic        w_unused;

  ioState_t    r_state;
  logic        r_ioEnPrev;
  logic [7:0]  r_cmd;
  logic [7:0]  r_cnt;
  logic [63:0] r_staging;
  logic [63:0] r_status;
  logic        r_statusUpd;
  logic [15:0] r_gpIn;
  logic [1:0]  r_buttons;
  logic [7:0]  r_switches;
  logic [31:0] r_joy [4];

  assign w_ioEn     = gp_out[IO_EN_BIT];
  assign w_word     = gp_out[15:0];
  assign w_ioEnFall = r_ioEnPrev & ~w_ioEn;
  // osd_en, fpga_en and the spare upper bits are deliberately ignored
  assign w_unused   = ^{gp_out[31:21], gp_out[19:16]};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ioEnPrev  <= 1'b0;
      r_cmd       <= 8'h00;
      r_cnt       <= 8'h00;
      r_staging   <= 64'h0;
      r_status    <= STATUS_INIT;
      r_statusUpd <= 1'b0;
      r_gpIn      <= 16'h0000;
      r_buttons   <= 2'b00;
      r_switches  <= 8'h00;
      for (int j = 0; j < 4; j++) r_joy[j] <= 32'h0;
    end else begin
      r_ioEnPrev  <= w_ioEn;
      r_statusUpd <= 1'b0;
      if (!w_ioEn) begin
        r_state <= ST_IDLE;
        r_gpIn  <= 16'h0000;
        // a SET transaction only takes effect once all four words have arrived
        if (w_ioEnFall && r_state == ST_DATA && r_cmd == CMD_STATUS_SET && r_cnt >= 8'd4) begin
          r_status    <= r_staging;
          r_statusUpd <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE, ST_CMD: begin
            if (io_strobe) begin
              r_state <= ST_DATA;
              r_cmd   <= w_word[7:0];
              r_cnt   <= 8'h00;
              r_gpIn  <= (w_word[7:0] == CMD_STATUS_GET) ? r_status[15:0] : 16'h0000;
            end else begin
              r_state <= ST_CMD;
            end
          end
          ST_DATA: begin
            if (io_strobe) begin
              if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
              r_gpIn <= 16'h0000;
              if (r_cmd == CMD_BUTTONS && r_cnt == 8'd0) begin
                r_buttons  <= w_word[1:0];
                r_switches <= w_word[15:8];
              end
              for (int j = 0; j < 4; j++) begin
                if (j < NUM_JOY && r_cmd == CMD_JOY0 + 8'(j)) begin
                  if (r_cnt == 8'd0) r_joy[j][15:0] <= w_word;
                  else if (r_cnt == 8'd1) r_joy[j][31:16] <= w_word;
                end
              end
              if (r_cmd == CMD_STATUS_SET && r_cnt < 8'd4)
                r_staging[{r_cnt[1:0], 4'b0000} +: 16] <= w_word;
              // the return word is always one slice ahead of the strobe index
              if (r_cmd == CMD_STATUS_GET) begin
                case (r_cnt)
                  8'd0:    r_gpIn <= r_status[31:16];
                  8'd1:    r_gpIn <= r_status[47:32];
                  8'd2:    r_gpIn <= r_status[63:48];
                  default: r_gpIn <= 16'h0000;
                endcase
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign gp_in      = r_gpIn;
  assign buttons    = r_buttons;
  assign switches   = r_switches;
  assign joy_0      = r_joy[0];
  assign joy_1      = r_joy[1];
  assign joy_2      = r_joy[2];
  assign joy_3      = r_joy[3];
  assign status     = r_status;
  assign status_upd = r_statusUpd;

endmodule

// File: tb/tb_hps_io_cmd.sv
// Directed self-checking bench for the HPS UIO command decoder.
module tb_hps_io_cmd;

  localparam logic [63:0] TB_INIT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ST4     = 64'h0004_0003_0002_0001;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [31:0] gp_out;
  logic        io_strobe;
  logic [15:0] gp_in;
  logic [1:0]  buttons;
  logic [7:0]  switches;
  logic [31:0] joy_0, joy_1, joy_2, joy_3;
  logic [63:0] status;
  logic        status_upd;

  int checkCount = 0;
  int errorCount = 0;

  hps_io_cmd #(.NUM_JOY(4), .STATUS_INIT(TB_INIT)) dut (
    .sys_clk(sys_clk), .reset(reset), .gp_out(gp_out), .io_strobe(io_strobe),
    .gp_in(gp_in), .buttons(buttons), .switches(switches),
    .joy_0(joy_0), .joy_1(joy_1), .joy_2(joy_2), .joy_3(joy_3),
    .status(status), .status_upd(status_upd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic setIoEn(input logic en);
    gp_out[20] = en;
    tick();
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    gp_out[15:0] = word;
    io_strobe    = 1'b1;
    tick();
    io_strobe    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; gp_out = 32'h0; io_strobe = 1'b0;
    tick(); tick();
    checkOutput("rst_status", status, TB_INIT);
    checkOutput("rst_buttons", 64'(buttons), 64'h0);
    checkOutput("rst_switches", 64'(switches), 64'h0);
    checkOutput("rst_joys", {joy_0 | joy_1, joy_2 | joy_3}, 64'h0);
    checkOutput("rst_gp_in", 64'(gp_in), 64'h0);
    checkOutput("rst_upd", 64'(status_upd), 64'h0);
    reset = 1'b0;
    tick();

    // buttons/switches
    setIoEn(1'b1);
    applyStimulus(16'h0001);
    checkOutput("btn_cmd_gp_in", 64'(gp_in), 64'h0);
    applyStimulus(16'hA503);
    applyStimulus(16'h0000);
    setIoEn(1'b0);
    checkOutput("btn_buttons", 64'(buttons), 64'h3);
    checkOutput("btn_switches", 64'(switches), 64'hA5);

    // joystick 1, halves written immediately, extra words ignored
    setIoEn(1'b1);
    applyStimulus(16'h0003);
    applyStimulus(16'h1234);
    checkOutput("joy1_lo", 64'(joy_1), 64'h0000_1234);
    applyStimulus(16'hBEEF);
    applyStimulus(16'h5555);
    setIoEn(1'b0);
    checkOutput("joy1_full", 64'(joy_1), 64'hBEEF_1234);
    checkOutput("joy0_untouched", 64'(joy_0), 64'h0);

    // full status set
    setIoEn(1'b1);
    applyStimulus(16'h001E);
    applyStimulus(16'h0001);
    applyStimulus(16'h0002);
    applyStimulus(16'h0003);
    applyStimulus(16'h0004);
    applyStimulus(16'h9999);
    checkOutput("set4_no_early_upd", 64'(status_upd), 64'h0);
    checkOutput("set4_no_early_status", status, TB_INIT);
    gp_out[20] = 1'b0;
    tick();
    checkOutput("set4_status", status, ST4);
    checkOutput("set4_upd_pulse", 64'(status_upd), 64'h1);
    tick();
    checkOutput("set4_upd_clear", 64'(status_upd), 64'h0);

    // short status set is discarded
    setIoEn(1'b1);
    applyStimulus(16'h001E);
    applyStimulus(16'h0007);
    applyStimulus(16'h0008);
    applyStimulus(16'h0009);
    gp_out[20] = 1'b0;
    tick();
    checkOutput("set3_upd", 64'(status_upd), 64'h0);
    checkOutput("set3_status", status, ST4);
    tick();
    checkOutput("set3_upd_late", 64'(status_upd), 64'h0);

    // status get returns successive slices
    setIoEn(1'b1);
    applyStimulus(16'h0029);
    checkOutput("get_w0", 64'(gp_in), 64'h0001);
    applyStimulus(16'h0000);
    checkOutput("get_w1", 64'(gp_in), 64'h0002);
    applyStimulus(16'h0000);
    checkOutput("get_w2", 64'(gp_in), 64'h0003);
    applyStimulus(16'h0000);
    checkOutput("get_w3", 64'(gp_in), 64'h0004);
    setIoEn(1'b0);
    checkOutput("get_idle_gp_in", 64'(gp_in), 64'h0);

    // fourth data strobe of a get is past the end and returns 0
    setIoEn(1'b1);
    checkOutput("cmd_state_gp_in", 64'(gp_in), 64'h0);
    applyStimulus(16'h0029);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    checkOutput("get_past_end", 64'(gp_in), 64'h0);
    setIoEn(1'b0);

    // unknown command has no effect
    setIoEn(1'b1);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    setIoEn(1'b0);
    checkOutput("nop_buttons", 64'(buttons), 64'h3);
    checkOutput("nop_switches", 64'(switches), 64'hA5);

    // strobe coincident with io_en falling is dropped
    setIoEn(1'b1);
    applyStimulus(16'h0002);
    gp_out[20] = 1'b0;
    applyStimulus(16'h4321);
    tick();
    checkOutput("drop_joy0", 64'(joy_0), 64'h0);

    // reset in the middle of a complete status set
    setIoEn(1'b1);
    applyStimulus(16'h001E);
    applyStimulus(16'h00AA);
    applyStimulus(16'h00BB);
    applyStimulus(16'h00CC);
    applyStimulus(16'h00DD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_status", status, TB_INIT);
    gp_out[20] = 1'b0;
    tick();
    checkOutput("midrst_no_upd", 64'(status_upd), 64'h0);
    checkOutput("midrst_status_kept", status, TB_INIT);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
